// File: rtl/lsu_mem_sequencer_if.sv
// Data-memory request/response bus between the load/store sequencer and memory.
// The sequencer drives the request side; memory drives acceptance and read responses.
interface lsu_mem_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// MEM-stage load/store sequencer: address generation, alignment check, byte lanes,
// memory handshake with optional timeout, and load extension.
module lsu_mem_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [5:0]           aluSelect,
    input  logic [31:0]          rs1,
    input  logic [31:0]          imm,
    input  logic [31:0]          store_data,
    output logic                 stall,
    output logic                 done,
    output logic [31:0]          load_data,
    output logic                 misaligned,
    output logic                 bus_error,
    lsu_mem_sequencer_if.master  mem
);
    localparam logic [5:0] OP_LB  = 6'b001011;
    localparam logic [5:0] OP_LH  = 6'b001100;
    localparam logic [5:0] OP_LW  = 6'b001101;
    localparam logic [5:0] OP_LBU = 6'b001110;
    localparam logic [5:0] OP_LHU = 6'b001111;
    localparam logic [5:0] OP_SB  = 6'b010000;
    localparam logic [5:0] OP_SH  = 6'b010001;
    localparam logic [5:0] OP_SW  = 6'b010010;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TIMER_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TIMER_LAST = TIMER_LAST_I[TW-1:0];

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state_reg, state_next;
    logic [5:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic              we_reg;
    logic              mis_reg;
    logic              berr_reg;
    logic [31:0]       ld_reg;
    logic [TW-1:0]     timer_reg;

    logic [31:0]       sum;
    logic [ADDR_W-1:0] eff_addr;
    logic              is_mem_in, is_store_in, mis_in;
    logic [1:0]        size_in;
    logic [3:0]        be_in;
    logic [31:0]       wdata_in;
    logic              accept, timeout_hit, complete_resp;
    logic [7:0]        rbyte [4];
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       ext_data;

    assign sum      = rs1 + imm;
    assign eff_addr = sum[ADDR_W-1:0];

    always_comb begin
        is_mem_in   = 1'b1;
        is_store_in = 1'b0;
        size_in     = 2'd2;
        case (aluSelect)
            OP_LB, OP_LBU: size_in = 2'd0;
            OP_LH, OP_LHU: size_in = 2'd1;
            OP_LW:         size_in = 2'd2;
            OP_SB:         begin size_in = 2'd0; is_store_in = 1'b1; end
            OP_SH:         begin size_in = 2'd1; is_store_in = 1'b1; end
            OP_SW:         begin size_in = 2'd2; is_store_in = 1'b1; end
            default:       is_mem_in = 1'b0;
        endcase
    end

    // Loads always enable all four lanes; the lane is picked on the response.
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = store_data;
        mis_in   = 1'b0;
        case (size_in)
            2'd0: begin
                if (is_store_in) be_in = 4'b0001 << eff_addr[1:0];
                wdata_in = {4{store_data[7:0]}};
            end
            2'd1: begin
                if (is_store_in) be_in = eff_addr[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data[15:0]}};
                mis_in   = eff_addr[0];
            end
            default: mis_in = (eff_addr[1:0] != 2'b00);
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = mem.mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign lane_b = rbyte[addr_reg[1:0]];
    assign lane_h = addr_reg[1] ? {rbyte[3], rbyte[2]} : {rbyte[1], rbyte[0]};

    always_comb begin
        ext_data = mem.mem_rdata;
        case (op_reg)
            OP_LB:   ext_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  ext_data = {24'd0, lane_b};
            OP_LH:   ext_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  ext_data = {16'd0, lane_h};
            default: ext_data = mem.mem_rdata;
        endcase
    end

    // Completion in the same cycle as the last timeout cycle wins over the fault.
    assign timeout_hit   = (TIMEOUT != 0) && (timer_reg == TIMER_LAST);
    assign complete_resp = (state_reg == RESP) && mem.mem_rvalid;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_in && is_mem_in) begin
                    accept     = 1'b1;
                    state_next = mis_in ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem.mem_ready)    state_next = we_reg ? DONE : RESP;
                else if (timeout_hit) state_next = DONE;
            end
            RESP: begin
                if (mem.mem_rvalid || timeout_hit) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            addr_reg  <= '0;
            be_reg    <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            mis_reg   <= 1'b0;
            berr_reg  <= 1'b0;
            ld_reg    <= '0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= aluSelect;
                addr_reg  <= eff_addr;
                be_reg    <= be_in;
                wdata_reg <= wdata_in;
                we_reg    <= is_store_in;
                mis_reg   <= mis_in;
                berr_reg  <= 1'b0;
                ld_reg    <= '0;
                timer_reg <= '0;
            end else if (state_reg == REQ || state_reg == RESP) begin
                timer_reg <= timer_reg + TW'(1);
            end
            if (complete_resp) begin
                ld_reg <= ext_data;
            end else if (timeout_hit &&
                         ((state_reg == REQ && !mem.mem_ready) || state_reg == RESP)) begin
                berr_reg <= 1'b1;
                ld_reg   <= '0;
            end
        end
    end

    assign mem.mem_req   = (state_reg == REQ);
    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign mem.mem_be    = be_reg;
    assign mem.mem_wdata = wdata_reg;

    assign done       = (state_reg == DONE);
    assign misaligned = done && mis_reg;
    assign bus_error  = done && berr_reg;
    assign load_data  = done ? ld_reg : 32'd0;

    assign stall = !reset && (((state_reg == IDLE) && valid_in && is_mem_in) ||
                              (state_reg == REQ) || (state_reg == RESP));
endmodule

// File: doc/lsu_mem_sequencer.md
# lsu_mem_sequencer

Sequential load/store unit for the RV32 pipeline's MEM stage. Computes the effective address, checks alignment, and generates byte strobes and lane-replicated store data. Runs a request/response handshake with the data memory, returns sign- or zero-extended load data, and stalls the pipeline until the access completes, faults, or times out.

## Interface
- ADDR_W, 32, memory address width; the effective address is (rs1 + imm) truncated to ADDR_W bits.
- TIMEOUT, 16, maximum cycles spent in REQ+RESP before bus_error; 0 disables the timeout.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  pipeline presents an operation this cycle.
- aluSelect  in  6  op code: 001011 LB, 001100 LH, 001101 LW, 001110 LBU, 001111 LHU, 010000 SB, 010001 SH, 010010 SW; any other value is a non-memory op.
- rs1  in  32  base register value.
- imm  in  32  sign-extended offset.
- store_data  in  32  rs2 value; low byte, low half or full word is used.
- stall  out  1  hold the pipeline.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid while done is high.
- misaligned  out  1  alignment fault; valid with done.
- bus_error  out  1  timeout fault; valid with done.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  word-aligned address (low two bits forced to 0).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  load response valid.
- mem_rdata  in  32  load response word.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - On valid_in with a memory op, register the op, address, byte enables and write data.
  - Misaligned access (halfword with addr[0]=1, word with addr[1:0]≠0) → DONE with misaligned=1. No mem_req is issued.
  - Otherwise → REQ.
  - Non-memory ops and mem_rvalid are ignored in IDLE.
- REQ: mem_req=1 with stable addr/we/be/wdata. On mem_ready: store → DONE, load → RESP.
- RESP: on mem_rvalid, capture the lane selected by addr[1:0], extend it, → DONE. mem_rvalid in the same cycle as mem_ready is not accepted; the response must arrive in RESP.
- DONE: done=1 for one cycle, → IDLE. A new op can be accepted in the following cycle.
- Timeout: a counter clears on entry to REQ and increments each cycle in REQ or RESP. When it reaches TIMEOUT without completion → DONE with bus_error=1 and load_data=0; mem_req drops.
- Byte enables:
  - SB: 0001 << addr[1:0]
  - SH: 0011 << {addr[1],1'b0}
  - SW: 1111
  - loads: 1111
- mem_wdata: SB {4{b}}, SH {2{h}}, SW word.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.

## Timing
- stall = (IDLE & valid_in & memory op) | REQ | RESP. It is combinational and forced to 0 while reset is high. stall is low in DONE.
- Zero-wait memory (mem_ready high in REQ, mem_rvalid one cycle later):
  - load: accept→done takes 3 cycles.
  - store: 2 cycles.
  - misaligned: 1 cycle.
- Each additional wait cycle on mem_ready or mem_rvalid adds one cycle.
- Reset values: state IDLE; stall, done, misaligned, bus_error, mem_req, mem_we all 0; mem_addr, mem_be, mem_wdata, load_data all 0.
- Reset mid-operation: returns to IDLE at the edge and drops mem_req. Any late mem_rvalid is then ignored.
- Address sum wraps modulo 2^ADDR_W. Example: rs1=FFFF_FFFC, imm=8 → 0000_0004.

## Test plan
- LW, rs1=0x100, imm=4, mem_rdata=0xDEADBEEF, zero-wait → mem_addr=0x104, mem_be=1111; done 3 cycles after accept; load_data=0xDEADBEEF.
- LB / LBU at addr 0x103, mem_rdata=0x80112233 → LB gives load_data=0xFFFFFF80; LBU gives 0x00000080.
- SH at addr 0x202, store_data=0x1234ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD; done 2 cycles after accept.
- LW at addr 0x101 → misaligned=1 with done 1 cycle after accept; mem_req never asserts.
- TIMEOUT=4, mem_ready held low → bus_error=1 and done after 4 REQ cycles; mem_req drops.
- Reset asserted during RESP, then mem_rvalid pulses → next cycle IDLE with all outputs 0; done does not assert.
